// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - two-road NS/EW traffic-light controller with tick-driven phase timing
//
// Purpose:
//   Six-phase traffic-light sequencer (EW_G, EW_Y, AR1, NS_G, NS_Y, AR2) with
//   programmable per-phase durations, pedestrian green truncation, night
//   flash mode and a two-level warning buzzer. All timing advances on the
//   one-clock `tick` strobe; every output is registered.
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   tick              - one-clock timing strobe
//   start, stop       - run while start=1 and stop=0; stop has priority
//   night             - flash mode while running
//   ped_req           - one-clock pedestrian request pulse
//   t_green_ew/ns     - green durations in ticks
//   t_yellow          - yellow duration in ticks, both roads
//   t_allred          - all-red clearance duration in ticks
//   lsng/lsny/lsnr    - NS green/yellow/red lamps
//   lewg/lewy/lewr    - EW green/yellow/red lamps
//   cnt               - ticks remaining in the current phase
//   ring              - buzzer code: 00 silent, 01 slow, 10 fast
//   state             - current state code

module traffic_ctrl_param #(
    parameter int CNT_W   = 8,
    parameter int WARN    = 3,
    parameter int PED_MIN = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             night,
    input  logic             ped_req,
    input  logic [CNT_W-1:0] t_green_ew,
    input  logic [CNT_W-1:0] t_green_ns,
    input  logic [CNT_W-1:0] t_yellow,
    input  logic [CNT_W-1:0] t_allred,
    output logic             lsng,
    output logic             lsny,
    output logic             lsnr,
    output logic             lewg,
    output logic             lewy,
    output logic             lewr,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       ring,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_EW_G  = 3'b001,
        S_EW_Y  = 3'b010,
        S_AR1   = 3'b011,
        S_NS_G  = 3'b100,
        S_NS_Y  = 3'b101,
        S_AR2   = 3'b110,
        S_FLASH = 3'b111
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PED_V    = CNT_W'(PED_MIN);
    localparam logic [CNT_W-1:0] WARN_V   = CNT_W'(WARN);

    localparam logic [1:0] RING_OFF  = 2'b00;
    localparam logic [1:0] RING_SLOW = 2'b01;
    localparam logic [1:0] RING_FAST = 2'b10;

    // Lamp vector order: {nsg, nsy, nsr, ewg, ewy, ewr}
    localparam logic [5:0] LAMP_ALL_RED = 6'b001_001;
    localparam logic [5:0] LAMP_EW_G    = 6'b001_100;
    localparam logic [5:0] LAMP_EW_Y    = 6'b001_010;
    localparam logic [5:0] LAMP_NS_G    = 6'b100_001;
    localparam logic [5:0] LAMP_NS_Y    = 6'b010_001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flash_q, flash_d;
    logic [1:0]       ring_q, ring_d;
    logic [5:0]       lamp_q, lamp_d;

    logic             run;
    logic             in_green;
    state_t           next_phase;
    logic [CNT_W-1:0] next_dur;

    // A programmed duration of zero still runs the phase for one tick.
    logic [CNT_W-1:0] dur_g_ew, dur_g_ns, dur_y, dur_ar;

    always_comb begin
        dur_g_ew = (t_green_ew == CNT_ZERO) ? CNT_ONE : t_green_ew;
        dur_g_ns = (t_green_ns == CNT_ZERO) ? CNT_ONE : t_green_ns;
        dur_y    = (t_yellow   == CNT_ZERO) ? CNT_ONE : t_yellow;
        dur_ar   = (t_allred   == CNT_ZERO) ? CNT_ONE : t_allred;
    end

    assign run      = start & ~stop;
    assign in_green = (state_q == S_EW_G) || (state_q == S_NS_G);

    // Successor in the normal cycle and the duration it loads on entry.
    always_comb begin
        next_phase = S_EW_G;
        next_dur   = dur_g_ew;
        case (state_q)
            S_EW_G: begin next_phase = S_EW_Y; next_dur = dur_y;    end
            S_EW_Y: begin next_phase = S_AR1;  next_dur = dur_ar;   end
            S_AR1:  begin next_phase = S_NS_G; next_dur = dur_g_ns; end
            S_NS_G: begin next_phase = S_NS_Y; next_dur = dur_y;    end
            S_NS_Y: begin next_phase = S_AR2;  next_dur = dur_ar;   end
            S_AR2:  begin next_phase = S_EW_G; next_dur = dur_g_ew; end
            default: begin next_phase = S_EW_G; next_dur = dur_g_ew; end
        endcase
    end

    // Next state / countdown / flash bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        if (!run) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            flash_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (night) begin
                        state_d = S_FLASH;
                        cnt_d   = CNT_ZERO;
                        flash_d = 1'b0;
                    end else begin
                        state_d = S_EW_G;
                        cnt_d   = dur_g_ew;
                    end
                end
                S_FLASH: begin
                    if (!night) begin
                        // Clear the junction before resuming the normal cycle.
                        state_d = S_AR2;
                        cnt_d   = dur_ar;
                        flash_d = 1'b0;
                    end else if (tick) begin
                        flash_d = ~flash_q;
                    end
                end
                default: begin
                    if (night) begin
                        state_d = S_FLASH;
                        cnt_d   = CNT_ZERO;
                        flash_d = 1'b0;
                    end else if (ped_req && in_green && (cnt_q > PED_V)) begin
                        // Truncation takes the whole clock; a coincident tick is dropped.
                        cnt_d = PED_V;
                    end else if (tick) begin
                        if (cnt_q > CNT_ONE) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end else begin
                            state_d = next_phase;
                            cnt_d   = next_dur;
                        end
                    end
                end
            endcase
        end
    end

    // Registered outputs are derived from the next state so they change on
    // the same clock as the state and countdown they describe.
    always_comb begin
        lamp_d = LAMP_ALL_RED;
        ring_d = RING_OFF;
        case (state_d)
            S_EW_G: begin
                lamp_d = LAMP_EW_G;
                if (cnt_d <= WARN_V) ring_d = RING_SLOW;
            end
            S_EW_Y: begin
                lamp_d = LAMP_EW_Y;
                ring_d = RING_FAST;
            end
            S_NS_G: begin
                lamp_d = LAMP_NS_G;
                if (cnt_d <= WARN_V) ring_d = RING_SLOW;
            end
            S_NS_Y: begin
                lamp_d = LAMP_NS_Y;
                ring_d = RING_FAST;
            end
            S_FLASH: lamp_d = {1'b0, flash_d, 1'b0, 1'b0, flash_d, 1'b0};
            default: lamp_d = LAMP_ALL_RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            flash_q <= 1'b0;
            ring_q  <= RING_OFF;
            lamp_q  <= LAMP_ALL_RED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
            ring_q  <= ring_d;
            lamp_q  <= lamp_d;
        end
    end

    assign {lsng, lsny, lsnr, lewg, lewy, lewr} = lamp_q;
    assign cnt   = cnt_q;
    assign ring  = ring_q;
    assign state = state_q;

endmodule
